// File: rtl/icmp_read.sv
// icmp_read: receives a 160-bit ICMP message as five 32-bit words, most
// significant word first, splits it into header fields and payload, and
// verifies the 16-bit ones'-complement checksum.
//
// Ports
//   clock        : single clock, rising edge
//   hardreset    : synchronous active-low reset
//   inputdata    : one 32-bit message word
//   inputvalid   : inputdata valid this cycle
//   inputsof     : start of message (word 0), qualified by inputvalid
//   msgvalid     : one-cycle pulse, a complete message is on the outputs
//   checksumok   : presented message summed to 16'hFFFF
//   icmptype     : word0[31:24]
//   icmpcode     : word0[23:16]
//   rxchecksum   : word0[15:0]
//   restofheader : word1
//   payload      : {word2, word3, word4}
//   framerr      : one-cycle pulse on a framing violation
//   goodcount    : saturating count of messages with checksumok = 1
//   badcount     : saturating count of messages with checksumok = 0
//
// state | meaning
// IDLE  | waiting for a start-of-message word
// W1    | word0 held, waiting for word1
// W2    | waiting for word2
// W3    | waiting for word3
// W4    | waiting for word4
// CHECK | message complete, present it (exactly one cycle)

module icmp_read (
  input  logic        clock,
  input  logic        hardreset,
  input  logic [31:0] inputdata,
  input  logic        inputvalid,
  input  logic        inputsof,
  output logic        msgvalid,
  output logic        checksumok,
  output logic [7:0]  icmptype,
  output logic [7:0]  icmpcode,
  output logic [15:0] rxchecksum,
  output logic [31:0] restofheader,
  output logic [95:0] payload,
  output logic        framerr,
  output logic [15:0] goodcount,
  output logic [15:0] badcount
);

  typedef enum logic [2:0] {IDLE, W1, W2, W3, W4, CHECK} state_t;

  state_t      state;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] word3;
  logic [31:0] word4;
  logic [15:0] acc;

  // Adds both halves of a word into a 16-bit ones'-complement sum. The 18-bit
  // raw sum needs two folds: the first can itself carry out of bit 15.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [31:0] w);
    logic [17:0] s;
    logic [16:0] t;
    s = {2'b00, a} + {2'b00, w[31:16]} + {2'b00, w[15:0]};
    t = {1'b0, s[15:0]} + {15'd0, s[17:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  always_ff @(posedge clock) begin
    if (!hardreset) begin
      state        <= IDLE;
      word0        <= '0;
      word1        <= '0;
      word2        <= '0;
      word3        <= '0;
      word4        <= '0;
      acc          <= '0;
      msgvalid     <= 1'b0;
      checksumok   <= 1'b0;
      icmptype     <= '0;
      icmpcode     <= '0;
      rxchecksum   <= '0;
      restofheader <= '0;
      payload      <= '0;
      framerr      <= 1'b0;
      goodcount    <= '0;
      badcount     <= '0;
    end else begin
      msgvalid <= 1'b0;
      framerr  <= 1'b0;
      case (state)
        IDLE: begin
          // Words without start-of-message are silently dropped here.
          if (inputvalid && inputsof) begin
            word0 <= inputdata;
            acc   <= oc_add(16'h0000, inputdata);
            state <= W1;
          end
        end
        W1, W2, W3, W4: begin
          if (inputvalid) begin
            if (inputsof) begin
              // New message interrupts a partial one: restart from word0.
              framerr <= 1'b1;
              word0   <= inputdata;
              acc     <= oc_add(16'h0000, inputdata);
              state   <= W1;
            end else begin
              acc <= oc_add(acc, inputdata);
              case (state)
                W1: begin word1 <= inputdata; state <= W2; end
                W2: begin word2 <= inputdata; state <= W3; end
                W3: begin word3 <= inputdata; state <= W4; end
                default: begin word4 <= inputdata; state <= CHECK; end
              endcase
            end
          end
        end
        CHECK: begin
          state        <= IDLE;
          msgvalid     <= 1'b1;
          checksumok   <= (acc == 16'hFFFF);
          icmptype     <= word0[31:24];
          icmpcode     <= word0[23:16];
          rxchecksum   <= word0[15:0];
          restofheader <= word1;
          payload      <= {word2, word3, word4};
          if (acc == 16'hFFFF) begin
            if (goodcount != 16'hFFFF) goodcount <= goodcount + 16'd1;
          end else begin
            if (badcount != 16'hFFFF) badcount <= badcount + 16'd1;
          end
          // The sender owes one idle cycle here; anything else is dropped.
          if (inputvalid) framerr <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_read.sv
module tb_icmp_read;

  logic        clock = 1'b0;
  logic        hardreset;
  logic [31:0] inputdata;
  logic        inputvalid;
  logic        inputsof;
  logic        msgvalid;
  logic        checksumok;
  logic [7:0]  icmptype;
  logic [7:0]  icmpcode;
  logic [15:0] rxchecksum;
  logic [31:0] restofheader;
  logic [95:0] payload;
  logic        framerr;
  logic [15:0] goodcount;
  logic [15:0] badcount;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  icmp_read dut (
    .clock(clock), .hardreset(hardreset), .inputdata(inputdata),
    .inputvalid(inputvalid), .inputsof(inputsof), .msgvalid(msgvalid),
    .checksumok(checksumok), .icmptype(icmptype), .icmpcode(icmpcode),
    .rxchecksum(rxchecksum), .restofheader(restofheader), .payload(payload),
    .framerr(framerr), .goodcount(goodcount), .badcount(badcount)
  );

  always #5 clock = ~clock;

  // Message-level reference: collects words into an array, and when five
  // have arrived presents them one cycle later with a checksum computed over
  // the whole message at once.
  logic [31:0] mw [5];
  int          nwords = 0;
  bit          pending = 0;
  logic        exp_msgvalid, exp_ok, exp_framerr;
  logic [7:0]  exp_type, exp_code;
  logic [15:0] exp_rx, exp_good, exp_bad;
  logic [31:0] exp_roh;
  logic [95:0] exp_pay;

  function automatic logic [15:0] msg_sum();
    int s = 0;
    for (int i = 0; i < 5; i++) s += mw[i][31:16] + mw[i][15:0];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  always @(posedge clock) begin
    exp_msgvalid = 1'b0;
    exp_framerr  = 1'b0;
    if (!hardreset) begin
      nwords = 0; pending = 0;
      exp_ok = 0; exp_type = 0; exp_code = 0; exp_rx = 0;
      exp_roh = 0; exp_pay = 0; exp_good = 0; exp_bad = 0;
    end else if (pending) begin
      pending      = 0;
      exp_msgvalid = 1'b1;
      exp_type     = mw[0][31:24];
      exp_code     = mw[0][23:16];
      exp_rx       = mw[0][15:0];
      exp_roh      = mw[1];
      exp_pay      = {mw[2], mw[3], mw[4]};
      exp_ok       = (msg_sum() == 16'hFFFF);
      if (exp_ok) begin
        if (exp_good != 16'hFFFF) exp_good = exp_good + 16'd1;
      end else begin
        if (exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
      end
      if (inputvalid) exp_framerr = 1'b1;
    end else if (inputvalid) begin
      if (inputsof) begin
        if (nwords > 0) exp_framerr = 1'b1;
        mw[0] = inputdata;
        nwords = 1;
      end else if (nwords > 0) begin
        mw[nwords] = inputdata;
        nwords++;
        if (nwords == 5) begin
          nwords  = 0;
          pending = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("msgvalid",     {95'd0, msgvalid},   {95'd0, exp_msgvalid});
      chk("framerr",      {95'd0, framerr},    {95'd0, exp_framerr});
      chk("checksumok",   {95'd0, checksumok}, {95'd0, exp_ok});
      chk("icmptype",     {88'd0, icmptype},   {88'd0, exp_type});
      chk("icmpcode",     {88'd0, icmpcode},   {88'd0, exp_code});
      chk("rxchecksum",   {80'd0, rxchecksum}, {80'd0, exp_rx});
      chk("restofheader", {64'd0, restofheader}, {64'd0, exp_roh});
      chk("payload",      payload,             exp_pay);
      chk("goodcount",    {80'd0, goodcount},  {80'd0, exp_good});
      chk("badcount",     {80'd0, badcount},   {80'd0, exp_bad});
    end
  end

  task automatic step(input logic v, input logic s, input logic [31:0] d);
    inputvalid = v;
    inputsof   = s;
    inputdata  = d;
    @(negedge clock);
  endtask

  task automatic send5(input logic [31:0] w0, w1, w2, w3, w4, input int gap);
    step(1, 1, w0);
    repeat (gap) step(0, 1, 32'hFFFF_FFFF);
    step(1, 0, w1);
    repeat (gap) step(0, 1, 32'hFFFF_FFFF);
    step(1, 0, w2);
    repeat (gap) step(0, 1, 32'hFFFF_FFFF);
    step(1, 0, w3);
    repeat (gap) step(0, 1, 32'hFFFF_FFFF);
    step(1, 0, w4);
  endtask

  task automatic lit_msg(input string tag, input logic [7:0] t, input logic [15:0] rx,
                         input logic ok, input logic [15:0] g, input logic [15:0] b);
    chk({tag, "_msgvalid"}, {95'd0, msgvalid}, 96'd1);
    chk({tag, "_type"}, {88'd0, icmptype}, {88'd0, t});
    chk({tag, "_rxcs"}, {80'd0, rxchecksum}, {80'd0, rx});
    chk({tag, "_ok"}, {95'd0, checksumok}, {95'd0, ok});
    chk({tag, "_good"}, {80'd0, goodcount}, {80'd0, g});
    chk({tag, "_bad"}, {80'd0, badcount}, {80'd0, b});
  endtask

  initial begin
    hardreset = 0; inputvalid = 0; inputsof = 0; inputdata = 0;
    @(negedge clock);
    @(negedge clock);
    checking = 1;
    chk("rst_msgvalid", {95'd0, msgvalid}, 96'd0);
    chk("rst_payload", payload, 96'd0);
    chk("rst_good", {80'd0, goodcount}, 96'd0);
    hardreset = 1;

    // Echo request, back-to-back words.
    send5(32'h0800F7FF, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    lit_msg("echo", 8'h08, 16'hF7FF, 1, 16'd1, 16'd0);
    chk("echo_code", {88'd0, icmpcode}, 96'd0);
    step(0, 0, 0);
    chk("echo_pulse_end", {95'd0, msgvalid}, 96'd0);
    chk("echo_hold_type", {88'd0, icmptype}, 96'h08);

    // Corrupted checksum.
    send5(32'h0800F7FE, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    lit_msg("corrupt", 8'h08, 16'hF7FE, 0, 16'd1, 16'd1);
    step(0, 0, 0);

    // Echo reply with 3 idle cycles between words. The halves of this vector
    // fold to 16'h1236, so the message fails the checksum.
    send5(32'h0000FFFF, 32'h12340001, 32'hDEADBEEF, 32'h21524111, 0, 3);
    step(0, 0, 0);
    chk("gap_payload", payload, 96'hDEADBEEF_21524111_00000000);
    chk("gap_roh", {64'd0, restofheader}, {64'd0, 32'h12340001});
    lit_msg("gap", 8'h00, 16'hFFFF, 0, 16'd1, 16'd2);
    step(0, 0, 0);
    // Same body with rxchecksum = ~16'h1236 sums to 16'hFFFF.
    send5(32'h0000EDC9, 32'h12340001, 32'hDEADBEEF, 32'h21524111, 0, 3);
    step(0, 0, 0);
    lit_msg("gapfix", 8'h00, 16'hEDC9, 1, 16'd2, 16'd2);
    step(0, 0, 0);

    // Restart: new start-of-message after two words.
    step(1, 1, 32'h0800F7FF);
    step(1, 0, 32'h11111111);
    step(1, 0, 32'h22222222);
    step(1, 1, 32'h0000FFFF);
    chk("restart_framerr", {95'd0, framerr}, 96'd1);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    lit_msg("restart", 8'h00, 16'hFFFF, 1, 16'd3, 16'd2);
    chk("restart_payload", payload, 96'd0);
    step(0, 0, 0);

    // Valid word during CHECK is dropped and flagged; stray non-sof word in IDLE is dropped.
    send5(32'h0800F7FF, 0, 0, 0, 0, 0);
    step(1, 0, 32'hAAAAAAAA);
    lit_msg("collide", 8'h08, 16'hF7FF, 1, 16'd4, 16'd2);
    chk("collide_framerr", {95'd0, framerr}, 96'd1);
    step(1, 0, 32'h12345678);
    step(0, 0, 0);
    chk("stray_framerr", {95'd0, framerr}, 96'd0);
    chk("stray_msgvalid", {95'd0, msgvalid}, 96'd0);

    // Reset after word 2.
    step(1, 1, 32'h0800F7FF);
    step(1, 0, 0);
    step(1, 0, 0);
    hardreset = 0;
    step(0, 0, 0);
    hardreset = 1;
    chk("rstmid_type", {88'd0, icmptype}, 96'd0);
    chk("rstmid_good", {80'd0, goodcount}, 96'd0);
    chk("rstmid_bad", {80'd0, badcount}, 96'd0);
    chk("rstmid_framerr", {95'd0, framerr}, 96'd0);
    step(0, 0, 0);
    send5(32'h0800F7FF, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    lit_msg("after_rst", 8'h08, 16'hF7FF, 1, 16'd1, 16'd0);
    step(0, 0, 0);

    // Reset glitch between edges must be ignored.
    step(1, 1, 32'h0800F7FF);
    step(1, 0, 0);
    inputvalid = 0;
    #2 hardreset = 0;
    #2 hardreset = 1;
    @(negedge clock);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    lit_msg("glitch", 8'h08, 16'hF7FF, 1, 16'd2, 16'd0);
    step(0, 0, 0);

    // Saturation: preload goodcount one below the ceiling.
    force dut.goodcount = 16'hFFFE;
    exp_good = 16'hFFFE;
    step(0, 0, 0);
    release dut.goodcount;
    step(0, 0, 0);
    send5(32'h0800F7FF, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    lit_msg("sat1", 8'h08, 16'hF7FF, 1, 16'hFFFF, 16'd0);
    step(0, 0, 0);
    send5(32'h0800F7FF, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    lit_msg("sat2", 8'h08, 16'hF7FF, 1, 16'hFFFF, 16'd0);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
